microwave_cook_timer: RTL and testbench

- Cook-time countdown stage directly upstream of the microwave control FSM.
- Loads a programmed cook time in seconds and counts it down while the FSM reports the Heat state.
- Holds the remaining time when heating is interrupted, e.g. by a door opening.
- Drives the FSM's `done` input when the count expires.

---
 rtl/microwave_pkg.sv | 27 ++
 rtl/sec_tick_gen.sv | 37 +++
 rtl/microwave_cook_timer.sv | 177 +++++++++++++++++
 tb/tb_microwave_cook_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook timer.
// Holds the control-FSM state codes the timer observes, the position of the
// heat bit within those codes, and the timer's own state encoding.
package microwave_pkg;

  // Control-FSM state codes, as presented on the timer's States input
  localparam logic [3:0] ST_IDLE   = 4'b0000;
  localparam logic [3:0] ST_CLOSED = 4'b0100;
  localparam logic [3:0] ST_START  = 4'b1100;
  localparam logic [3:0] ST_HEAT0  = 4'b1110;
  localparam logic [3:0] ST_HEAT   = 4'b0110;
  localparam logic [3:0] ST_ERR    = 4'b1001;
  localparam logic [3:0] ST_ERR_CL = 4'b1101;

  // Bit of the control-FSM code that is high in every heating state
  localparam int unsigned HEAT_BIT = 1;

  // Cook-timer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    FIN   = 3'd4
  } tmr_state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler.
// Counts 0..DIV-1 while enabled and emits a one-cycle tick on the last count;
// holds its count while disabled so a partial second survives a pause.
// Ports:
//   clk, sys_reset_n : clock, asynchronous active-low reset
//   i_en             : advance the count this cycle
//   i_clr            : synchronously return the count to 0 (wins over i_en)
//   o_tick_c         : combinational tick, high on the wrapping cycle
module sec_tick_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic sys_reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == CW'(DIV - 1));

  // Prescaler count
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_tick_c) r_cnt <= '0;
      else          r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_cook_timer.sv
// Cook-time countdown in front of the microwave control FSM.
// Loads a cook time in seconds, counts it down while the control FSM is in a
// heating state, holds it across interruptions and raises done on expiry.
// Optional alarm: define MICROWAVE_COOK_TIMER_BEEP_EN to drive beep for
// BEEP_SEC seconds from expiry; otherwise beep is tied low.
// Ports:
//   clk, sys_reset_n : clock, asynchronous active-low reset
//   load, time_in    : one-cycle strobe capturing a cook time in seconds
//   abort            : one-cycle strobe returning the timer to IDLE
//   States           : control-FSM state code; States[HEAT_BIT] means heating
//   done             : level, high in FIN until heating stops
//   running          : high while counting down
//   remaining        : seconds left
//   beep             : expiry alarm
module microwave_cook_timer
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned TW       = 12,
  parameter int unsigned BEEP_SEC = 3
) (
  input  logic          clk,
  input  logic          sys_reset_n,
  input  logic          load,
  input  logic [TW-1:0] time_in,
  input  logic          abort,
  input  logic [3:0]    States,
  output logic          done,
  output logic          running,
  output logic [TW-1:0] remaining,
  output logic          beep
);

  tmr_state_t    r_state;
  logic [TW-1:0] r_remaining;
  logic          r_done;
  logic          r_running;

  logic w_heat;
  logic w_tick;
  logic w_tick_clr;
  logic w_expire;
  logic w_unused_states;

  assign w_heat          = States[HEAT_BIT];
  assign w_unused_states = ^{States[3:2], States[0]};

  // Prescaler only advances in RUN and keeps its count through PAUSE
  assign w_tick_clr = (r_state == IDLE) || (r_state == ARMED) || (r_state == FIN);

  sec_tick_gen #(
    .DIV (TICK_DIV)
  ) u_sec_tick (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .i_en        (r_state == RUN),
    .i_clr       (w_tick_clr),
    .o_tick_c    (w_tick)
  );

  assign w_expire = w_tick && (r_remaining == TW'(1));

  // Timer FSM with registered outputs
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_running <= 1'b0;
      if (abort) begin
        r_state     <= IDLE;
        r_remaining <= '0;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (load && (time_in != '0)) begin
              r_state     <= ARMED;
              r_remaining <= time_in;
            end
          end
          ARMED: begin
            if (load) begin
              r_remaining <= time_in;
              if (time_in == '0) r_state <= IDLE;
            end else if (w_heat) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            // remaining is at least 1 here, so the decrement cannot wrap
            if (w_tick) r_remaining <= r_remaining - TW'(1);
            // Expiry wins over heat falling in the same cycle
            if (w_expire)     r_state <= FIN;
            else if (!w_heat) r_state <= PAUSE;
            else              r_running <= 1'b1;
          end
          PAUSE: begin
            if (load && (time_in != '0)) begin
              r_state     <= ARMED;
              r_remaining <= time_in;
            end else if (w_heat) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          FIN: begin
            // done is issued for at least one cycle even if heat already fell
            r_done <= 1'b1;
            if (r_done && !w_heat) begin
              r_state <= IDLE;
              r_done  <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign done      = r_done;
  assign running   = r_running;
  assign remaining = r_remaining;

`ifdef MICROWAVE_COOK_TIMER_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_SEC + 1);

  logic          r_beep;
  logic [BW-1:0] r_beep_sec;
  logic          w_beep_tick;
  logic          w_fin_entry;

  assign w_fin_entry = (r_state == RUN) && w_expire && !abort;

  // Independent seconds count so the alarm outlives FIN
  sec_tick_gen #(
    .DIV (TICK_DIV)
  ) u_beep_tick (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .i_en        (r_beep),
    .i_clr       (!r_beep || w_fin_entry),
    .o_tick_c    (w_beep_tick)
  );

  // Alarm duration; a new load leaves it running
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_beep     <= 1'b0;
      r_beep_sec <= '0;
    end else if (abort) begin
      r_beep     <= 1'b0;
      r_beep_sec <= '0;
    end else if (w_fin_entry) begin
      r_beep     <= 1'b1;
      r_beep_sec <= '0;
    end else if (r_beep && w_beep_tick) begin
      if (r_beep_sec == BW'(BEEP_SEC - 1)) begin
        r_beep     <= 1'b0;
        r_beep_sec <= '0;
      end else begin
        r_beep_sec <= r_beep_sec + BW'(1);
      end
    end
  end

  assign beep = r_beep;
`else
  logic w_unused_beep_cfg;
  assign w_unused_beep_cfg = |BEEP_SEC;
  assign beep              = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Directed bench for microwave_cook_timer with TICK_DIV=4.
module tb_microwave_cook_timer;
  import microwave_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned TW       = 12;

  logic          clk = 1'b0;
  logic          sys_reset_n;
  logic          load;
  logic [TW-1:0] time_in;
  logic          abort;
  logic [3:0]    States;
  logic          done;
  logic          running;
  logic [TW-1:0] remaining;
  logic          beep;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  microwave_cook_timer #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW),
    .BEEP_SEC (3)
  ) dut (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .load        (load),
    .time_in     (time_in),
    .abort       (abort),
    .States      (States),
    .done        (done),
    .running     (running),
    .remaining   (remaining),
    .beep        (beep)
  );

  typedef struct {
    logic          ld;
    logic [TW-1:0] tin;
    logic          ab;
    logic [3:0]    st;
    logic          e_done;
    logic          e_run;
    logic [TW-1:0] e_rem;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic ld, int tin, logic ab, logic [3:0] st,
                             logic ed, logic er, int erem);
    vec_t r;
    r.ld = ld; r.tin = TW'(tin); r.ab = ab; r.st = st;
    r.e_done = ed; r.e_run = er; r.e_rem = TW'(erem);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ed, input logic er, input int erem);
    chk({tag, ".done"},      32'(done),      32'(ed));
    chk({tag, ".running"},   32'(running),   32'(er));
    chk({tag, ".remaining"}, 32'(remaining), 32'(erem));
  endtask

  // Drive inputs mid-cycle, let one rising edge pass, sample just after it
  task automatic cyc(input logic ld, input int tin, input logic ab, input logic [3:0] st);
    @(negedge clk);
    load = ld; time_in = TW'(tin); abort = ab; States = st;
    @(posedge clk);
    #1;
  endtask

  int beep_cycles;

  initial begin
    sys_reset_n = 1'b0;
    load = 1'b0; time_in = '0; abort = 1'b0; States = ST_CLOSED;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 0);
    chk("reset.beep", 32'(beep), 32'd0);
    @(negedge clk);
    sys_reset_n = 1'b1;

    // Zero load, basic countdown of 3 s, load ignored in RUN, exit via door
    vt.push_back(v(1, 0, 0, ST_CLOSED, 0, 0, 0));   // zero load stays IDLE
    vt.push_back(v(1, 3, 0, ST_CLOSED, 0, 0, 3));   // ARMED
    vt.push_back(v(0, 0, 0, ST_CLOSED, 0, 0, 3));
    vt.push_back(v(0, 0, 0, ST_HEAT0,  0, 1, 3));   // RUN entry
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 3));   // +1
    vt.push_back(v(1, 9, 0, ST_HEAT,   0, 1, 3));   // +2 load ignored
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 3));   // +3
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 2));   // +4 first tick
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 2));
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 2));
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 2));
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 1));   // +8
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 1));
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 1));
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 1, 1));
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 0, 0));   // +12 expiry -> FIN
    vt.push_back(v(0, 0, 0, ST_HEAT,   1, 0, 0));   // +13 done
    vt.push_back(v(0, 0, 0, ST_HEAT,   1, 0, 0));   // held while heating
    vt.push_back(v(0, 0, 0, ST_CLOSED, 0, 0, 0));   // back to IDLE
    vt.push_back(v(0, 0, 0, ST_HEAT,   0, 0, 0));   // IDLE ignores heat

    foreach (vt[i]) begin
      cyc(vt[i].ld, int'(vt[i].tin), vt[i].ab, vt[i].st);
      chk_out($sformatf("vec%0d", i), vt[i].e_done, vt[i].e_run, int'(vt[i].e_rem));
    end

    // Pause after a partial second, then resume
    cyc(1, 5, 0, ST_CLOSED);
    cyc(0, 0, 0, ST_HEAT0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, ST_HEAT);
    chk_out("pause.tick1", 1'b0, 1'b1, 4);
    cyc(0, 0, 0, ST_HEAT);
    cyc(0, 0, 0, ST_CLOSED);
    chk_out("pause.enter", 1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, ST_CLOSED);
      chk_out($sformatf("pause.hold%0d", i), 1'b0, 1'b0, 4);
    end
    cyc(0, 0, 0, ST_HEAT);
    chk_out("resume.0", 1'b0, 1'b1, 4);
    cyc(0, 0, 0, ST_HEAT);
    chk_out("resume.1", 1'b0, 1'b1, 4);
    cyc(0, 0, 0, ST_HEAT);
    chk_out("resume.2", 1'b0, 1'b1, 3);
    cyc(0, 0, 1, ST_CLOSED);
    chk_out("pause.abort", 1'b0, 1'b0, 0);

    // Abort beats load in ARMED
    cyc(1, 5, 0, ST_CLOSED);
    chk_out("armed", 1'b0, 1'b0, 5);
    cyc(1, 7, 1, ST_CLOSED);
    chk_out("abort_load", 1'b0, 1'b0, 0);
    cyc(0, 0, 0, ST_HEAT);
    chk_out("abort_load.idle", 1'b0, 1'b0, 0);

    // Abort on the expiring cycle
    cyc(1, 1, 0, ST_CLOSED);
    cyc(0, 0, 0, ST_HEAT0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, ST_HEAT);
    chk_out("abort_exp.pre", 1'b0, 1'b1, 1);
    cyc(0, 0, 1, ST_HEAT);
    chk_out("abort_exp", 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, ST_HEAT);
      chk_out($sformatf("abort_exp.after%0d", i), 1'b0, 1'b0, 0);
    end

    // Expiry coincident with heat falling still issues done
    cyc(0, 0, 0, ST_CLOSED);
    cyc(1, 1, 0, ST_CLOSED);
    cyc(0, 0, 0, ST_HEAT0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, ST_HEAT);
    cyc(0, 0, 0, ST_CLOSED);
    chk_out("simul.fin", 1'b0, 1'b0, 0);
    cyc(0, 0, 0, ST_CLOSED);
    chk_out("simul.done", 1'b1, 1'b0, 0);
    cyc(0, 0, 0, ST_CLOSED);
    chk_out("simul.idle", 1'b0, 1'b0, 0);

    // Asynchronous reset between edges while running
    cyc(1, 7, 0, ST_CLOSED);
    cyc(0, 0, 0, ST_HEAT0);
    cyc(0, 0, 0, ST_HEAT);
    cyc(0, 0, 0, ST_HEAT);
    chk_out("rst_mid.pre", 1'b0, 1'b1, 7);
    #1;
    sys_reset_n = 1'b0;
    #1;
    chk_out("rst_mid.async", 1'b0, 1'b0, 0);
    @(negedge clk);
    sys_reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, ST_HEAT);
      chk_out($sformatf("rst_mid.after%0d", i), 1'b0, 1'b0, 0);
    end

    // Alarm length from a 1 s cook
    cyc(0, 0, 1, ST_CLOSED);
    cyc(1, 1, 0, ST_CLOSED);
    cyc(0, 0, 0, ST_HEAT0);
    beep_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, ST_HEAT);
      if (beep === 1'b1) beep_cycles++;
    end
`ifdef MICROWAVE_COOK_TIMER_BEEP_EN
    chk("beep.cycles", 32'(beep_cycles), 32'd12);
`else
    chk("beep.cycles", 32'(beep_cycles), 32'd0);
`endif
    chk_out("beep.fin", 1'b1, 1'b0, 0);
    cyc(0, 0, 0, ST_CLOSED);
    chk_out("beep.exit", 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
